pe_sequencer: RTL and testbench

Initiator-side controller for one SIMD processing element (PE). It accepts a job (vector length code plus operand stream), loads operand vector A then B into the PE, runs the PE's multiply-accumulate to completion, and reads back the dot product. The result is returned on a valid/ready port. It sits between the array-level dispatcher and each PE instance.

---
 rtl/pe_seq_pkg.sv | 23 ++
 rtl/pe_seq_if.sv | 23 ++
 rtl/pe_seq_watchdog.sv | 29 ++
 rtl/pe_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pe_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE sequencer.
// Holds the FSM state enum and the length-code helper.
package pe_seq_pkg;

    localparam int MAX_LEN = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_A,
        S_SWAP,
        S_LOAD_B,
        S_MAC,
        S_RESP
    } state_t;

    // Length code 0..3 -> vector length 2/4/8/16
    function automatic logic [4:0] dimen_len(input logic [1:0] code);
        return 5'd2 << code;
    endfunction

endpackage

// File: rtl/pe_seq_if.sv
// Dispatcher-side streams of the PE sequencer.
// IN_*: operand stream into the block; RES_*: result stream out.
interface pe_seq_if;
    import pe_seq_pkg::*;

    logic              IN_VALID;
    logic              IN_READY;
    logic [WORD_W-1:0] IN_DATA;
    logic              RES_VALID;
    logic              RES_READY;
    logic [WORD_W-1:0] RES_DATA;

    modport master (
        output IN_VALID, IN_DATA, RES_READY,
        input  IN_READY, RES_VALID, RES_DATA
    );

    modport slave (
        input  IN_VALID, IN_DATA, RES_READY,
        output IN_READY, RES_VALID, RES_DATA
    );

endinterface

// File: rtl/pe_seq_watchdog.sv
// MAC-phase cycle counter for the PE sequencer.
// Ports: CLK, RST, ACTIVE (in MAC), DONE (PE finished), EXPIRE.
module pe_seq_watchdog #(
    parameter int MAC_TIMEOUT = 24
) (
    input  logic CLK,
    input  logic RST,
    input  logic ACTIVE,
    input  logic DONE,
    output logic EXPIRE
);

    localparam int CW = $clog2(MAC_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Count 0 on the first MAC cycle; expiry fires in the
    // MAC_TIMEOUT-th cycle so the abort lands one edge later.
    always_ff @(posedge CLK) begin
        if (RST || !ACTIVE || DONE)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign EXPIRE = ACTIVE && !DONE &&
                    (cnt == CW'(MAC_TIMEOUT - 1));

endmodule

// File: rtl/pe_sequencer.sv
// Initiator-side job controller for one SIMD PE: loads A then B,
// runs the MAC, returns the dot product on the result stream.
// Ports: CLK, RST, START, DIMEN_IN, BUSY, ERR, io (pe_seq_if.slave),
// PE side RST_ADD/RST_PC/RST_ACC/WRITE_MAT/MAT_MUX/MAC_CTRL/
// OUT_READY/DIMEN/DATAIN out, MAC_DONE/DATAOUT in.
// Build macro PE_SEQ_WATCHDOG_EN adds the MAC timeout and ERR.
module pe_sequencer
    import pe_seq_pkg::*;
#(
    parameter int MAC_TIMEOUT = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        DIMEN_IN,
    output logic              BUSY,
    output logic              ERR,
    pe_seq_if.slave           io,
    output logic              RST_ADD,
    output logic              RST_PC,
    output logic              RST_ACC,
    output logic              WRITE_MAT,
    output logic              MAT_MUX,
    output logic              MAC_CTRL,
    output logic              OUT_READY,
    output logic [1:0]        DIMEN,
    output logic [WORD_W-1:0] DATAIN,
    input  logic              MAC_DONE,
    input  logic [WORD_W-1:0] DATAOUT
);

    state_t            state, state_n;
    logic [4:0]        cnt, cnt_n;
    logic [4:0]        len;
    logic [WORD_W-1:0] res_q;
    logic              capture;
    logic              dimen_ld;
    logic              err_set;
    logic              err_clr;
    logic              wd_expire;

    assign len         = dimen_len(DIMEN);
    assign io.RES_DATA = res_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            DIMEN <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (dimen_ld) DIMEN <= DIMEN_IN;
            if (capture)  res_q <= DATAOUT;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        BUSY        = (state != S_IDLE);
        io.IN_READY = 1'b0;
        io.RES_VALID = 1'b0;
        RST_ADD     = 1'b0;
        RST_PC      = 1'b0;
        RST_ACC     = 1'b0;
        WRITE_MAT   = 1'b0;
        MAT_MUX     = 1'b0;
        MAC_CTRL    = 1'b0;
        OUT_READY   = 1'b0;
        DATAIN      = '0;
        capture     = 1'b0;
        dimen_ld    = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    dimen_ld = 1'b1;
                    err_clr  = 1'b1;
                    state_n  = S_CLR;
                end
            end
            S_CLR: begin
                RST_ADD = 1'b1;
                RST_PC  = 1'b1;
                RST_ACC = 1'b1;
                cnt_n   = '0;
                state_n = S_LOAD_A;
            end
            S_LOAD_A, S_LOAD_B: begin
                io.IN_READY = 1'b1;
                MAT_MUX     = (state == S_LOAD_A);
                WRITE_MAT   = io.IN_VALID;
                DATAIN      = io.IN_DATA;
                if (io.IN_VALID) begin
                    if (cnt == len - 5'd1) begin
                        cnt_n   = '0;
                        state_n = (state == S_LOAD_A) ?
                                  S_SWAP : S_MAC;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            S_SWAP: begin
                RST_ADD = 1'b1;
                cnt_n   = '0;
                state_n = S_LOAD_B;
            end
            S_MAC: begin
                // Gating on MAC_DONE keeps the PE from adding
                // an element past the vector end.
                MAC_CTRL  = ~MAC_DONE;
                OUT_READY = MAC_DONE;
                if (MAC_DONE) begin
                    capture = 1'b1;
                    state_n = S_RESP;
                end else if (wd_expire) begin
                    MAC_CTRL = 1'b0;
                    RST_ADD  = 1'b1;
                    RST_PC   = 1'b1;
                    RST_ACC  = 1'b1;
                    err_set  = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            S_RESP: begin
                io.RES_VALID = 1'b1;
                if (io.RES_READY) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Hold the PE cleared and the ports quiet while in reset
        if (RST) begin
            state_n      = S_IDLE;
            BUSY         = 1'b0;
            io.IN_READY  = 1'b0;
            io.RES_VALID = 1'b0;
            WRITE_MAT    = 1'b0;
            MAT_MUX      = 1'b0;
            MAC_CTRL     = 1'b0;
            OUT_READY    = 1'b0;
            DATAIN       = '0;
            RST_ADD      = 1'b1;
            RST_PC       = 1'b1;
            RST_ACC      = 1'b1;
        end
    end

`ifdef PE_SEQ_WATCHDOG_EN
    logic err_q;

    pe_seq_watchdog #(
        .MAC_TIMEOUT(MAC_TIMEOUT)
    ) u_wd (
        .CLK    (CLK),
        .RST    (RST),
        .ACTIVE (state == S_MAC),
        .DONE   (MAC_DONE),
        .EXPIRE (wd_expire)
    );

    always_ff @(posedge CLK) begin
        if (RST)          err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
        else if (err_clr) err_q <= 1'b0;
    end

    assign ERR = err_q;
`else
    logic unused_cfg;

    assign wd_expire  = 1'b0;
    assign ERR        = 1'b0;
    assign unused_cfg = err_set | err_clr |
                        (MAC_TIMEOUT > MAX_LEN);
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer paired with a behavioural PE.
// Directed jobs with hand-computed dot products and latencies.
module tb_pe_sequencer;
    import pe_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  DIMEN_IN;
    logic        BUSY;
    logic        ERR;
    logic        RST_ADD, RST_PC, RST_ACC;
    logic        WRITE_MAT, MAT_MUX, MAC_CTRL, OUT_READY;
    logic [1:0]  DIMEN;
    logic [31:0] DATAIN;
    logic        MAC_DONE;
    logic [31:0] DATAOUT;

    pe_seq_if io ();

    always #5 CLK = ~CLK;

    pe_sequencer #(.MAC_TIMEOUT(24)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DIMEN_IN  (DIMEN_IN),
        .BUSY      (BUSY),
        .ERR       (ERR),
        .io        (io.slave),
        .RST_ADD   (RST_ADD),
        .RST_PC    (RST_PC),
        .RST_ACC   (RST_ACC),
        .WRITE_MAT (WRITE_MAT),
        .MAT_MUX   (MAT_MUX),
        .MAC_CTRL  (MAC_CTRL),
        .OUT_READY (OUT_READY),
        .DIMEN     (DIMEN),
        .DATAIN    (DATAIN),
        .MAC_DONE  (MAC_DONE),
        .DATAOUT   (DATAOUT)
    );

    // Behavioural PE: address-indexed A/B stores and a MAC unit
    logic [31:0] ma [16];
    logic [31:0] mb [16];
    logic [4:0]  addr, pc, pe_len;
    logic [31:0] acc;
    bit          pe_hang = 1'b0;

    assign pe_len   = 5'd2 << DIMEN;
    assign MAC_DONE = !pe_hang && (pc == pe_len);
    assign DATAOUT  = acc;

    always @(posedge CLK) begin
        if (WRITE_MAT) begin
            if (MAT_MUX) ma[addr[3:0]] <= DATAIN;
            else         mb[addr[3:0]] <= DATAIN;
            addr <= addr + 5'd1;
        end
        if (MAC_CTRL && pc < pe_len) begin
            acc <= acc + ma[pc[3:0]] * mb[pc[3:0]];
            pc  <= pc + 5'd1;
        end
        if (RST_ADD) addr <= '0;
        if (RST_PC)  pc   <= '0;
        if (RST_ACC) acc  <= '0;
    end

    int cyc = 0;
    int wm_cnt = 0;
    int wm_bad = 0;
    int rv_cnt = 0;
    int n_run = 0;
    int n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WRITE_MAT) wm_cnt++;
        if (WRITE_MAT && !io.IN_VALID) wm_bad++;
        if (io.RES_VALID) rv_cnt++;
    end

    logic [31:0] wq [$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"},
            32'({BUSY, io.IN_READY, io.RES_VALID, ERR,
                 WRITE_MAT, MAC_CTRL, OUT_READY, MAT_MUX}), 0);
        chk({tag, "_pe_rst"},
            32'({RST_ADD, RST_PC, RST_ACC}), 32'h7);
        chk({tag, "_res"}, io.RES_DATA, 0);
        chk({tag, "_dimen"}, 32'(DIMEN), 0);
    endtask

    task automatic run_job(input logic [1:0] dm,
                           input bit stall,
                           output int lat,
                           output logic [31:0] res);
        int t0, idx, n, g;
        bit acc_w;
        n = 2 * (2 << dm);
        DIMEN_IN = dm;
        START = 1'b1;
        t0 = cyc;
        @(posedge CLK); #1;
        START = 1'b0;
        idx = 0;
        g = 0;
        while (idx < n && g < 200) begin
            io.IN_VALID = stall ? g[0] : 1'b1;
            io.IN_DATA  = wq[idx];
            @(negedge CLK);
            acc_w = io.IN_VALID && io.IN_READY;
            @(posedge CLK); #1;
            if (acc_w) idx++;
            g++;
        end
        io.IN_VALID = 1'b0;
        chk("feed_done", idx, n);
        g = 0;
        while (!io.RES_VALID && g < 200) begin
            @(posedge CLK); #1;
            g++;
        end
        chk("resp_seen", 32'(io.RES_VALID), 1);
        lat = cyc - t0;
        res = io.RES_DATA;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        int lat, wm0, bad0, g, e, rv0;
        logic [31:0] res;

        RST = 1'b1;
        START = 1'b0;
        DIMEN_IN = '0;
        io.IN_VALID = 1'b0;
        io.IN_DATA = '0;
        io.RES_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset("rst");
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("idle_pe_rst", 32'({RST_ADD, RST_PC, RST_ACC}), 0);

        // L=2: 3*5 + 4*6 = 39, valid at T0+10
        wm0 = wm_cnt;
        wq = '{32'd3, 32'd4, 32'd5, 32'd6};
        run_job(2'd0, 1'b0, lat, res);
        chk("l2_res", res, 39);
        chk("l2_lat", lat, 10);
        chk("l2_wm", wm_cnt - wm0, 4);
        @(posedge CLK); #1;
        chk("l2_idle", 32'(BUSY), 0);

        // L=4 with IN_VALID low every other cycle: 1+2+3+4
        bad0 = wm_bad;
        wq = '{32'd1, 32'd2, 32'd3, 32'd4,
               32'd1, 32'd1, 32'd1, 32'd1};
        run_job(2'd1, 1'b1, lat, res);
        chk("l4_res", res, 10);
        chk("l4_wm_bad", wm_bad - bad0, 0);
        chk("l4_dimen", 32'(DIMEN), 1);
        @(posedge CLK); #1;

        // 2 * 2^32 wraps to 0
        wq = '{32'h10000, 32'h10000, 32'h10000, 32'h10000};
        run_job(2'd0, 1'b0, lat, res);
        chk("wrap_res", res, 0);
        @(posedge CLK); #1;

        // L=16, all ones: sum 16, valid at T0+52
        wq.delete();
        for (int i = 0; i < 32; i++) wq.push_back(32'd1);
        run_job(2'd3, 1'b0, lat, res);
        chk("l16_res", res, 16);
        chk("l16_lat", lat, 52);
        @(posedge CLK); #1;

        // Result back-pressure with START hammered
        io.RES_READY = 1'b0;
        wq = '{32'd3, 32'd4, 32'd5, 32'd6};
        run_job(2'd0, 1'b0, lat, res);
        chk("bp_res", res, 39);
        for (int i = 0; i < 5; i++) begin
            START = 1'b1;
            DIMEN_IN = 2'd2;
            @(posedge CLK); #1;
            chk("bp_valid", 32'(io.RES_VALID), 1);
            chk("bp_data", io.RES_DATA, 39);
            chk("bp_busy", 32'(BUSY), 1);
        end
        io.RES_READY = 1'b1;
        DIMEN_IN = 2'd1;
        @(posedge CLK); #1;
        chk("bp_idle", 32'(BUSY), 0);
        chk("bp_novalid", 32'(io.RES_VALID), 0);
        @(posedge CLK); #1;
        START = 1'b0;
        chk("bp_restart", 32'(BUSY), 1);
        chk("bp_dimen", 32'(DIMEN), 1);

        // Run the L=4 job into LOAD_B, then reset mid-load
        io.IN_VALID = 1'b1;
        io.IN_DATA = 32'h55;
        g = 0;
        while (!(io.IN_READY && !MAT_MUX) && g < 40) begin
            @(posedge CLK); #1;
            g++;
        end
        chk("in_load_b", 32'({io.IN_READY, MAT_MUX}), 2);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        io.IN_VALID = 1'b0;
        chk_reset("midrst");
        RST = 1'b0;
        @(posedge CLK); #1;

        wq = '{32'd3, 32'd4, 32'd5, 32'd6};
        run_job(2'd0, 1'b0, lat, res);
        chk("post_rst_res", res, 39);
        chk("post_rst_lat", lat, 10);
        @(posedge CLK); #1;

`ifdef PE_SEQ_WATCHDOG_EN
        // Hung PE: ERR at MAC entry + 24, back to IDLE
        pe_hang = 1'b1;
        DIMEN_IN = 2'd0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        io.IN_VALID = 1'b1;
        io.IN_DATA = 32'd7;
        g = 0;
        while (!MAC_CTRL && g < 50) begin
            @(posedge CLK); #1;
            g++;
        end
        io.IN_VALID = 1'b0;
        chk("wd_mac", 32'(MAC_CTRL), 1);
        e = cyc;
        rv0 = rv_cnt;
        g = 0;
        while (!ERR && g < 100) begin
            @(posedge CLK); #1;
            g++;
        end
        chk("wd_err", 32'(ERR), 1);
        chk("wd_lat", cyc - e, 24);
        chk("wd_idle", 32'(BUSY), 0);
        chk("wd_norv", rv_cnt - rv0, 0);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("wd_clr", 32'(ERR), 0);
        pe_hang = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
